uart_rx_param: RTL and testbench

//  Parametrised UART receiver, successor to UART_Rx_module: configurable data width, oversampling and runtime baud divisor.

---
 rtl/uart_rx_param_if.sv | 50 +++++
 rtl/uart_rx_param.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Bundle of configuration, serial-line, FIFO-side and status signals of the
// parametrised UART receiver. The receiver uses the slave view; whoever
// drives the configuration, the serial line and the FIFO status uses the
// master view.
interface uart_rx_param_if #(
    parameter int DATA_W = 8
);
    logic              Cfg_ctrl_stopbit;
    logic [1:0]        Cfg_ctrl_paritybit;
    logic              Cfg_ctrl_Rx_en;
    logic [15:0]       Cfg_baud_div;
    logic              Rx_bit;
    logic              FIFO_ctrl_full;
    logic [DATA_W-1:0] UART_Rx_data_payload;
    logic              UART_ctrl_FIFO_w_en;
    logic              Rx_parity_err;
    logic              Rx_frame_err;
    logic              Rx_overrun_err;
    logic              Rx_busy;

    modport master (
        output Cfg_ctrl_stopbit,
        output Cfg_ctrl_paritybit,
        output Cfg_ctrl_Rx_en,
        output Cfg_baud_div,
        output Rx_bit,
        output FIFO_ctrl_full,
        input  UART_Rx_data_payload,
        input  UART_ctrl_FIFO_w_en,
        input  Rx_parity_err,
        input  Rx_frame_err,
        input  Rx_overrun_err,
        input  Rx_busy
    );

    modport slave (
        input  Cfg_ctrl_stopbit,
        input  Cfg_ctrl_paritybit,
        input  Cfg_ctrl_Rx_en,
        input  Cfg_baud_div,
        input  Rx_bit,
        input  FIFO_ctrl_full,
        output UART_Rx_data_payload,
        output UART_ctrl_FIFO_w_en,
        output Rx_parity_err,
        output Rx_frame_err,
        output Rx_overrun_err,
        output Rx_busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// Recovers DATA_W-bit LSB-first frames from an oversampled serial line using
// a three-sample majority vote around mid-bit, rejects false starts, and
// reports parity, framing and overrun errors as single-cycle pulses in the
// same cycle the word is offered to the Rx FIFO.
module uart_rx_param #(
    parameter int DATA_W = 8,   // data bits per frame, 5..9
    parameter int OVS    = 16   // oversample ticks per bit, even, 8..32
) (
    input  logic           glb_clk,
    input  logic           glb_rst,
    uart_rx_param_if.slave bus
);

    localparam int TICK_W = $clog2(OVS);
    localparam int BCNT_W = $clog2(DATA_W + 1);

    // Tick indices inside one bit: two early samples, the mid-bit decision
    // tick (third sample) and the last tick of the bit.
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVS / 2);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVS / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(OVS - 1);
    localparam logic [BCNT_W-1:0] BITS_ALL  = BCNT_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_DONE
    } state_t;

    // Line synchroniser and edge history
    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync_d;

    // Timing
    state_t            r_state;
    logic [15:0]       r_div;
    logic [15:0]       r_presc;
    logic [TICK_W-1:0] r_tick;
    logic [BCNT_W-1:0] r_bit_cnt;

    // Bit recovery and frame assembly
    logic              r_samp0;
    logic              r_samp1;
    logic [DATA_W-1:0] r_shift;

    // Per-frame configuration captured at the start edge
    logic              r_two_stop;
    logic              r_par_en;
    logic              r_par_odd;

    // Errors accumulated during the frame, reported in DONE
    logic              r_par_err_lat;
    logic              r_frame_err_lat;

    // Registered outputs
    logic [DATA_W-1:0] r_payload;
    logic              r_w_en;
    logic              r_par_err;
    logic              r_frame_err;
    logic              r_overrun_err;

    logic              w_fall;
    logic              w_start;
    logic              w_tick;
    logic              w_mid;
    logic              w_end;
    logic              w_vote;
    logic [15:0]       w_div_eff;
    logic              w_par_calc;

    // A divisor of zero behaves exactly like a divisor of one.
    assign w_div_eff = (bus.Cfg_baud_div == 16'd0) ? 16'd1 : bus.Cfg_baud_div;

    // Start condition: receiver enabled and a 1->0 transition on the
    // synchronised line.
    assign w_fall    = r_sync_d & ~r_sync2;
    assign w_start   = bus.Cfg_ctrl_Rx_en & w_fall;

    // One oversample tick per r_div clocks; r_div is at least 1.
    assign w_tick    = (r_presc == (r_div - 16'd1));
    assign w_mid     = w_tick & (r_tick == TICK_MID);
    assign w_end     = w_tick & (r_tick == TICK_END);

    // Majority of the two stored samples and the live sample at mid-bit.
    assign w_vote    = (r_samp0 & r_samp1) | (r_samp0 & r_sync2) | (r_samp1 & r_sync2);

    // Mismatch flag: XOR of data and received parity bit must be 1 for odd
    // parity and 0 for even parity.
    assign w_par_calc = (^r_shift) ^ w_vote ^ r_par_odd;

    assign bus.UART_Rx_data_payload = r_payload;
    assign bus.UART_ctrl_FIFO_w_en  = r_w_en;
    assign bus.Rx_parity_err        = r_par_err;
    assign bus.Rx_frame_err         = r_frame_err;
    assign bus.Rx_overrun_err       = r_overrun_err;
    assign bus.Rx_busy              = (r_state != S_IDLE);

    // Two-flop synchroniser for the asynchronous line plus one history flop
    // for falling-edge detection; all three idle high.
    always_ff @(posedge glb_clk) begin
        // NOTE: non-blocking assignments make every flop sample the values
        // from before the clock edge, so the chain really is three stages.
        if (glb_rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= bus.Rx_bit;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Receive FSM with prescaler, tick counter, sampling and registered outputs.
    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            r_state         <= S_IDLE;
            r_div           <= 16'd1;
            r_presc         <= '0;
            r_tick          <= '0;
            r_bit_cnt       <= '0;
            r_samp0         <= 1'b1;
            r_samp1         <= 1'b1;
            r_shift         <= '0;
            r_two_stop      <= 1'b0;
            r_par_en        <= 1'b0;
            r_par_odd       <= 1'b0;
            r_par_err_lat   <= 1'b0;
            r_frame_err_lat <= 1'b0;
            r_payload       <= '0;
            r_w_en          <= 1'b0;
            r_par_err       <= 1'b0;
            r_frame_err     <= 1'b0;
            r_overrun_err   <= 1'b0;
        end else begin
            // NOTE: every pulse output gets a default here, so it drops after
            // one cycle and no path can leave it holding a stale value.
            r_w_en        <= 1'b0;
            r_par_err     <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;

            // Prescaler and tick counter run only while a frame is in flight.
            if (r_state == S_IDLE || r_state == S_DONE) begin
                r_presc <= '0;
                r_tick  <= '0;
            end else begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_tick  <= (r_tick == TICK_END) ? '0 : r_tick + 1'b1;
                end else begin
                    r_presc <= r_presc + 16'd1;
                end
                if (w_tick && r_tick == TICK_S0) r_samp0 <= r_sync2;
                if (w_tick && r_tick == TICK_S1) r_samp1 <= r_sync2;
            end

            if (r_state != S_IDLE && !bus.Cfg_ctrl_Rx_en) begin
                // Disable aborts the frame silently; the partial word is lost.
                r_state <= S_IDLE;
                r_presc <= '0;
                r_tick  <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        // DONE also watches for a start edge so that a frame
                        // following immediately after is not missed.
                        if (w_start) begin
                            r_state         <= S_START;
                            r_presc         <= '0;
                            r_tick          <= '0;
                            r_bit_cnt       <= '0;
                            r_div           <= w_div_eff;
                            r_two_stop      <= bus.Cfg_ctrl_stopbit;
                            r_par_en        <= (bus.Cfg_ctrl_paritybit == 2'b01) ||
                                               (bus.Cfg_ctrl_paritybit == 2'b10);
                            r_par_odd       <= (bus.Cfg_ctrl_paritybit == 2'b01);
                            r_par_err_lat   <= 1'b0;
                            r_frame_err_lat <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end

                    S_START: begin
                        if (w_mid && w_vote) begin
                            r_state <= S_IDLE;          // glitch, not a start bit
                        end else if (w_end) begin
                            r_state <= S_DATA;
                        end
                    end

                    S_DATA: begin
                        if (w_mid) begin
                            r_shift   <= {w_vote, r_shift[DATA_W-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                        if (w_end && r_bit_cnt == BITS_ALL) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP1;
                        end
                    end

                    S_PARITY: begin
                        if (w_mid) begin
                            r_par_err_lat <= w_par_calc;
                        end
                        if (w_end) begin
                            r_state <= S_STOP1;
                        end
                    end

                    S_STOP1: begin
                        if (w_mid && !w_vote) begin
                            r_frame_err_lat <= 1'b1;
                        end
                        if (w_mid && !r_two_stop) begin
                            // Finish at mid-bit so the next start edge is
                            // already watched for during the rest of stop.
                            r_state       <= S_DONE;
                            r_frame_err   <= r_frame_err_lat | ~w_vote;
                            r_par_err     <= r_par_err_lat;
                            r_overrun_err <= bus.FIFO_ctrl_full;
                            r_w_en        <= ~bus.FIFO_ctrl_full;
                            if (!bus.FIFO_ctrl_full) begin
                                r_payload <= r_shift;
                            end
                        end else if (w_end && r_two_stop) begin
                            r_state <= S_STOP2;
                        end
                    end

                    S_STOP2: begin
                        if (w_mid) begin
                            r_state         <= S_DONE;
                            r_frame_err_lat <= r_frame_err_lat | ~w_vote;
                            r_frame_err     <= r_frame_err_lat | ~w_vote;
                            r_par_err       <= r_par_err_lat;
                            r_overrun_err   <= bus.FIFO_ctrl_full;
                            r_w_en          <= ~bus.FIFO_ctrl_full;
                            if (!bus.FIFO_ctrl_full) begin
                                r_payload <= r_shift;
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus random
// frames. Every frame that should complete pushes its expected DONE-cycle
// response into a scoreboard; a monitor pops and compares whenever the DUT
// pulses any output.
module tb_uart_rx_param;

    localparam int DATA_W = 8;
    localparam int OVS    = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              w_en;
        logic              par;
        logic              frame;
        logic              ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_W(DATA_W)) u_if ();

    uart_rx_param #(
        .DATA_W (DATA_W),
        .OVS    (OVS)
    ) dut (
        .glb_clk (clk),
        .glb_rst (rst),
        .bus     (u_if)
    );

    exp_t              sb[$];
    exp_t              mon_e;
    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] last_written = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any DONE-cycle activity must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && (u_if.UART_ctrl_FIFO_w_en || u_if.Rx_parity_err ||
                     u_if.Rx_frame_err || u_if.Rx_overrun_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_output",
                      64'({u_if.UART_ctrl_FIFO_w_en, u_if.Rx_parity_err,
                           u_if.Rx_frame_err, u_if.Rx_overrun_err}), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("done_flags",
                      64'({u_if.UART_ctrl_FIFO_w_en, u_if.Rx_parity_err,
                           u_if.Rx_frame_err, u_if.Rx_overrun_err}),
                      64'({mon_e.w_en, mon_e.par, mon_e.frame, mon_e.ovr}));
                check("payload", 64'(u_if.UART_Rx_data_payload), 64'(mon_e.data));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int eff_div(input int div);
        return (div == 0) ? 1 : div;
    endfunction

    task automatic drive_bit(input logic b, input int div);
        u_if.Rx_bit = b;
        wait_cycles(OVS * eff_div(div));
    endtask

    // One full frame followed by an idle gap. The expected response is
    // derived from the frame rules and pushed before the first bit.
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic [1:0] mode,
                              input logic two_stop, input logic pbit,
                              input logic s1, input logic s2, input logic full,
                              input int div, input int gap);
        exp_t e;
        int   ones;
        logic par_en;
        par_en = (mode == 2'b01) || (mode == 2'b10);
        ones   = $countones(data) + int'(pbit);
        e.par   = par_en && ((mode == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1));
        e.frame = !s1 || (two_stop && !s2);
        e.ovr   = full;
        e.w_en  = !full;
        if (!full) last_written = data;
        e.data  = last_written;
        sb.push_back(e);

        u_if.Cfg_ctrl_paritybit = mode;
        u_if.Cfg_ctrl_stopbit   = two_stop;
        u_if.Cfg_baud_div       = 16'(div);
        u_if.FIFO_ctrl_full     = full;

        drive_bit(1'b0, div);
        for (int i = 0; i < DATA_W; i++) drive_bit(data[i], div);
        if (par_en) drive_bit(pbit, div);
        drive_bit(s1, div);
        if (two_stop) drive_bit(s2, div);

        u_if.Rx_bit         = 1'b1;
        u_if.FIFO_ctrl_full = 1'b0;
        check("written_within_stop", 64'(sb.size()), 64'd0);
        check("idle_after_frame", 64'(u_if.Rx_busy), 64'd0);
        wait_cycles(gap);
    endtask

    // Start bit plus a few data bits, leaving the line low mid-DATA.
    task automatic partial_frame(input int div);
        u_if.Cfg_baud_div = 16'(div);
        drive_bit(1'b0, div);
        drive_bit(1'b0, div);
        drive_bit(1'b1, div);
        u_if.Rx_bit = 1'b0;
        wait_cycles(OVS * eff_div(div) / 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic [1:0]        mode;
        logic              two, pb, s1, s2, full, last_bad;
        int                div, gap;

        u_if.Cfg_ctrl_stopbit   = 1'b0;
        u_if.Cfg_ctrl_paritybit = 2'b00;
        u_if.Cfg_ctrl_Rx_en     = 1'b1;
        u_if.Cfg_baud_div       = 16'd1;
        u_if.Rx_bit             = 1'b1;
        u_if.FIFO_ctrl_full     = 1'b0;

        // Reset state
        rst = 1'b1;
        wait_cycles(5);
        check("reset_w_en",    64'(u_if.UART_ctrl_FIFO_w_en), 64'd0);
        check("reset_errs",    64'({u_if.Rx_parity_err, u_if.Rx_frame_err, u_if.Rx_overrun_err}), 64'd0);
        check("reset_payload", 64'(u_if.UART_Rx_data_payload), 64'd0);
        check("reset_busy",    64'(u_if.Rx_busy), 64'd0);
        rst = 1'b0;
        wait_cycles(10);
        check("idle_busy", 64'(u_if.Rx_busy), 64'd0);

        // T1: 8N1, div=1
        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 20);

        // T2: odd parity, correct then wrong parity bit
        send_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 20);
        send_frame(8'h03, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 20);

        // T3: two stop bits, second one low
        send_frame(8'hC6, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 40);

        // T4: overrun, then a normal frame
        send_frame(8'h5A, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 20);
        send_frame(8'hC3, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 20);

        // T5: short low glitch is a false start
        u_if.Cfg_baud_div = 16'd2;
        u_if.Rx_bit = 1'b0;
        wait_cycles(4 * 2);
        u_if.Rx_bit = 1'b1;
        check("glitch_start_seen", 64'(u_if.Rx_busy), 64'd1);
        wait_cycles(2 * OVS * 2);
        check("glitch_rejected", 64'(u_if.Rx_busy), 64'd0);

        // T5: back-to-back frames, no idle gap
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 20);

        // T6: Rx_en dropped mid-DATA
        partial_frame(1);
        check("busy_mid_data", 64'(u_if.Rx_busy), 64'd1);
        u_if.Cfg_ctrl_Rx_en = 1'b0;
        wait_cycles(2);
        check("abort_busy", 64'(u_if.Rx_busy), 64'd0);
        u_if.Rx_bit = 1'b1;
        wait_cycles(OVS * 2);
        u_if.Cfg_ctrl_Rx_en = 1'b1;
        wait_cycles(10);
        send_frame(8'h7E, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 20);

        // T6: reset mid-DATA
        partial_frame(1);
        rst = 1'b1;
        wait_cycles(2);
        check("midreset_busy",    64'(u_if.Rx_busy), 64'd0);
        check("midreset_payload", 64'(u_if.UART_Rx_data_payload), 64'd0);
        last_written = '0;
        u_if.Rx_bit  = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(OVS * 2);
        check("after_reset_busy", 64'(u_if.Rx_busy), 64'd0);
        send_frame(8'h7E, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 20);

        // Random frames: data, parity mode/bit, stop bits, divisor (incl. 0),
        // FIFO full and bad stop bits.
        for (int n = 0; n < 24; n++) begin
            d    = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            mode = 2'($urandom_range(0, 3));
            two  = 1'($urandom_range(0, 1));
            pb   = 1'($urandom_range(0, 1));
            s1   = ($urandom_range(0, 5) != 0);
            s2   = ($urandom_range(0, 5) != 0);
            full = ($urandom_range(0, 5) == 0);
            div  = $urandom_range(0, 3);
            gap  = $urandom_range(0, 2 * OVS);
            last_bad = two ? !s2 : !s1;
            if (last_bad) gap += OVS * eff_div(div);
            send_frame(d, mode, two, pb, s1, s2, full, div, gap);
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
